// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: RV32I encodings, datapath mux selects and the
// control word. Build with DECODE_STAGE_RV32M_EN defined to add the RV32M decode fields.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
    axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;
endpackage

package regfilemux;
  typedef enum logic [3:0] {
    alu_out, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu, md_out
  } regfilemux_sel_t;
endpackage

package alumux;
  typedef enum logic { rs1_out, pc_out } alumux1_sel_t;
  typedef enum logic [2:0] { i_imm, u_imm, b_imm, s_imm, j_imm, rs2_out } alumux2_sel_t;
endpackage

package cmpmux;
  typedef enum logic { rs2_out, i_imm } cmpmux_sel_t;
endpackage

package control_itf;
  import rv32i_types::*;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_MD  = 7'b0000001;

  typedef enum logic [2:0] {
    md_mul, md_mulh, md_mulhsu, md_mulhu, md_div, md_divu, md_rem, md_remu
  } mdop_t;

  typedef struct packed {
    rv32i_opcode                  opcode;
    alu_ops                       aluop;
    branch_funct3_t               cmpop;
    regfilemux::regfilemux_sel_t  regfilemux_sel;
    alumux::alumux1_sel_t         alumux1_sel;
    alumux::alumux2_sel_t         alumux2_sel;
    cmpmux::cmpmux_sel_t          cmpmux_sel;
    logic                         load_regfile;
    logic                         dcache_read;
    logic                         dcache_write;
    logic                         mask1;
    logic                         mask2;
    logic                         illegal;
`ifdef DECODE_STAGE_RV32M_EN
    logic                         md_en;
    mdop_t                        mdop;
`endif
  } ctrl_word;
endpackage

// File: rtl/decode_stage_rom.sv
// Combinational control ROM: opcode/funct3/funct7/rd to ctrl_word plus source-usage flags.
// RV32M decode is included when DECODE_STAGE_RV32M_EN is defined.
module decode_rom
  import rv32i_types::*;
  import control_itf::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  output ctrl_word   ctrl,
  output logic       rs1_used,
  output logic       rs2_used
);
  logic bad;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl        = '0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    bad         = 1'b0;
    ctrl.opcode = rv32i_opcode'(opcode);

    case (rv32i_opcode'(opcode))
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel  = alumux::pc_out;
        ctrl.alumux2_sel  = alumux::u_imm;
      end
      op_jal: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
        ctrl.alumux1_sel    = alumux::pc_out;
        ctrl.alumux2_sel    = alumux::j_imm;
      end
      op_jalr: begin
        rs1_used            = 1'b1;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_br: begin
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        ctrl.cmpop       = branch_funct3_t'(funct3);
        ctrl.alumux1_sel = alumux::pc_out;
        ctrl.alumux2_sel = alumux::b_imm;
      end
      op_load: begin
        rs1_used          = 1'b1;
        ctrl.load_regfile = 1'b1;
        ctrl.dcache_read  = 1'b1;
        case (load_funct3_t'(funct3))
          lb:      ctrl.regfilemux_sel = regfilemux::lb;
          lh:      ctrl.regfilemux_sel = regfilemux::lh;
          lbu:     ctrl.regfilemux_sel = regfilemux::lbu;
          lhu:     ctrl.regfilemux_sel = regfilemux::lhu;
          default: ctrl.regfilemux_sel = regfilemux::lw;
        endcase
      end
      op_store: begin
        rs1_used          = 1'b1;
        rs2_used          = 1'b1;
        ctrl.dcache_write = 1'b1;
        ctrl.alumux2_sel  = alumux::s_imm;
      end
      op_imm: begin
        rs1_used          = 1'b1;
        ctrl.load_regfile = 1'b1;
        case (arith_funct3_t'(funct3))
          slt: begin
            ctrl.cmpop = blt; ctrl.cmpmux_sel = cmpmux::i_imm; ctrl.regfilemux_sel = regfilemux::br_en;
          end
          sltu: begin
            ctrl.cmpop = bltu; ctrl.cmpmux_sel = cmpmux::i_imm; ctrl.regfilemux_sel = regfilemux::br_en;
          end
          sr:      ctrl.aluop = (funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
          default: ctrl.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        if (funct7 == 7'b0000000 || funct7 == FUNCT7_ALT) begin
          ctrl.load_regfile = 1'b1;
          ctrl.alumux2_sel  = alumux::rs2_out;
          case (arith_funct3_t'(funct3))
            add:  ctrl.aluop = (funct7 == FUNCT7_ALT) ? alu_sub : alu_add;
            slt:  begin ctrl.cmpop = blt;  ctrl.regfilemux_sel = regfilemux::br_en; end
            sltu: begin ctrl.cmpop = bltu; ctrl.regfilemux_sel = regfilemux::br_en; end
            sr:      ctrl.aluop = (funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
            default: ctrl.aluop = alu_ops'(funct3);
          endcase
        end
`ifdef DECODE_STAGE_RV32M_EN
        else if (funct7 == FUNCT7_MD) begin
          ctrl.load_regfile   = 1'b1;
          ctrl.regfilemux_sel = regfilemux::md_out;
          ctrl.md_en          = 1'b1;
          ctrl.mdop           = mdop_t'(funct3);
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    // Unsupported encodings must not touch architectural state; mask1 tells execute to squash.
    if (bad) begin
      ctrl.illegal      = 1'b1;
      ctrl.load_regfile = 1'b0;
      ctrl.dcache_read  = 1'b0;
      ctrl.dcache_write = 1'b0;
      ctrl.mask1        = 1'b1;
      ctrl.mask2        = 1'b0;
    end
    if (rd == 5'd0) ctrl.load_regfile = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched instructions into a DEPTH-entry in-order queue with
// load-use tagging and flush. RV32M decode is enabled by DECODE_STAGE_RV32M_EN.
module decode_stage
  import rv32i_types::*;
  import control_itf::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_word        out_ctrl,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            out_load_use
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  ctrl_word        mem_ctrl     [DEPTH];
  logic [PC_W-1:0] mem_pc       [DEPTH];
  logic [31:0]     mem_instr    [DEPTH];
  logic            mem_load_use [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             last_is_load;
  logic [4:0]       last_rd;

  ctrl_word dec_ctrl;
  logic     rs1_used, rs2_used, load_use_in, push, pop;

  decode_rom u_rom (
    .opcode   (in_instr[6:0]),
    .funct3   (in_instr[14:12]),
    .funct7   (in_instr[31:25]),
    .rd       (in_instr[11:7]),
    .ctrl     (dec_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered count, so out_ready never reaches it combinationally.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign load_use_in = last_is_load && (last_rd != 5'd0) &&
                       ((rs1_used && in_instr[19:15] == last_rd) ||
                        (rs2_used && in_instr[24:20] == last_rd));

  // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_is_load <= 1'b0;
      last_rd      <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_is_load <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr       <= next_ptr(wr_ptr);
        last_is_load <= (dec_ctrl.opcode == op_load);
        last_rd      <= in_instr[11:7];
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the entries are reset on purpose so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_ctrl[i]     <= '0;
        mem_pc[i]       <= '0;
        mem_instr[i]    <= '0;
        mem_load_use[i] <= 1'b0;
      end
    end else if (push) begin
      mem_ctrl[wr_ptr]     <= dec_ctrl;
      mem_pc[wr_ptr]       <= in_pc;
      mem_instr[wr_ptr]    <= in_instr;
      mem_load_use[wr_ptr] <= load_use_in;
    end
  end

  assign out_ctrl     = mem_ctrl[rd_ptr];
  assign out_pc       = mem_pc[rd_ptr];
  assign out_instr    = mem_instr[rd_ptr];
  assign out_load_use = mem_load_use[rd_ptr];
  assign out_illegal  = out_ctrl.illegal;
  assign out_rs1      = out_instr[19:15];
  assign out_rs2      = out_instr[24:20];
  assign out_rd       = out_instr[11:7];
endmodule
